// File: rtl/seg_scan6_if.sv
// -----------------------------------------------------------------------------
// seg_scan6_if
// Bundle between the key-count logic and the six-digit display scanner.
//   data_i     [23:0] six hex nibbles, data_i[3:0] is digit 0 (rightmost)
//   dp_i       [5:0]  decimal-point enable per digit
//   blank_en_i        suppress leading zeros when 1
//   sel_o      [2:0]  binary index of the lit digit (0..5) to the 3-to-8 decoder
//   seg_o      [7:0]  active-low segments {dp,g,f,e,d,c,b,a}, common-anode
// master = producer of the value (and consumer of the pins), slave = scanner.
// -----------------------------------------------------------------------------
interface seg_scan6_if;
  logic [23:0] data_i;
  logic [5:0]  dp_i;
  logic        blank_en_i;
  logic [2:0]  sel_o;
  logic [7:0]  seg_o;

  modport master (
    output data_i, dp_i, blank_en_i,
    input  sel_o, seg_o
  );

  modport slave (
    input  data_i, dp_i, blank_en_i,
    output sel_o, seg_o
  );
endinterface : seg_scan6_if

// File: rtl/seg_scan6.sv
// -----------------------------------------------------------------------------
// seg_scan6
// Time-multiplexes a six-digit hex value onto a common-anode seven-segment
// display. Each digit stays lit for SCAN_CNT clocks. The input value, dp
// enables and blanking mode are snapshotted once per frame (on the edge that
// returns to digit 0), so an update in the middle of a scan never tears.
//   clk  system clock, rising edge
//   rst  synchronous, active-high reset
//   bus  seg_scan6_if.slave: data_i/dp_i/blank_en_i in, sel_o/seg_o out
// Parameters:
//   SCAN_CNT  clocks per digit, >= 2
// -----------------------------------------------------------------------------
module seg_scan6 #(
  parameter int unsigned SCAN_CNT = 50_000
) (
  input  logic       clk,
  input  logic       rst,
  seg_scan6_if.slave bus
);

  localparam int unsigned PW = (SCAN_CNT > 1) ? $clog2(SCAN_CNT) : 1;
  localparam logic [PW-1:0] PCNT_LAST = PW'(SCAN_CNT - 1);
  localparam logic [2:0]    IDX_LAST  = 3'd5;

  // Active-low hex font; bit 7 (dp) is forced off here and applied separately.
  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [7:0] c;
    case (n)
      4'h0: c = 8'hC0;  4'h1: c = 8'hF9;  4'h2: c = 8'hA4;  4'h3: c = 8'hB0;
      4'h4: c = 8'h99;  4'h5: c = 8'h92;  4'h6: c = 8'h82;  4'h7: c = 8'hF8;
      4'h8: c = 8'h80;  4'h9: c = 8'h90;  4'hA: c = 8'h88;  4'hB: c = 8'h83;
      4'hC: c = 8'hC6;  4'hD: c = 8'hA1;  4'hE: c = 8'h86;  default: c = 8'h8E;
    endcase
    return c[6:0];
  endfunction

  logic [PW-1:0] pcnt_q, pcnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [23:0]   frame_data_q;
  logic [5:0]    frame_dp_q;
  logic          frame_blank_q;
  logic [2:0]    sel_q;
  logic [7:0]    seg_q, seg_d;

  logic          tick, wrap;
  logic [23:0]   src_data;
  logic [5:0]    src_dp;
  logic          src_blank;
  logic [7:0]    dp_ext;
  logic [7:0]    zero_from;   // zero_from[i]: nibble i and all above are 0
  logic [3:0]    nibble;
  logic          blank_digit;

  // NOTE: every signal written here gets a default first so no path leaves a
  // value unassigned; a missed branch in combinational logic infers a latch.
  always_comb begin
    tick   = (pcnt_q == PCNT_LAST);
    wrap   = tick && (idx_q == IDX_LAST);
    pcnt_d = tick ? '0 : pcnt_q + PW'(1);

    idx_d = idx_q;
    if (wrap)      idx_d = 3'd0;
    else if (tick) idx_d = idx_q + 3'd1;

    // On the wrap edge digit 0 is decoded from the value being snapshotted,
    // so the first digit of a frame already shows the new data.
    src_data  = wrap ? bus.data_i     : frame_data_q;
    src_dp    = wrap ? bus.dp_i       : frame_dp_q;
    src_blank = wrap ? bus.blank_en_i : frame_blank_q;

    dp_ext = {2'b00, src_dp};

    zero_from      = 8'h00;
    zero_from[5]   = (src_data[23:20] == 4'h0);
    for (int i = 4; i >= 0; i--) begin
      zero_from[i] = zero_from[i+1] && (src_data[4*i +: 4] == 4'h0);
    end

    case (idx_d)
      3'd0:    nibble = src_data[3:0];
      3'd1:    nibble = src_data[7:4];
      3'd2:    nibble = src_data[11:8];
      3'd3:    nibble = src_data[15:12];
      3'd4:    nibble = src_data[19:16];
      3'd5:    nibble = src_data[23:20];
      default: nibble = 4'h0;
    endcase

    // Digit 0 is never blanked, so a value of zero still shows one "0".
    blank_digit = src_blank && (idx_d != 3'd0) && zero_from[idx_d];

    // The decimal point survives blanking.
    seg_d = {~dp_ext[idx_d], blank_digit ? 7'h7F : hex7(nibble)};
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt_q        <= '0;
      idx_q         <= IDX_LAST;   // first tick wraps and snapshots a frame
      frame_data_q  <= '0;
      frame_dp_q    <= '0;
      frame_blank_q <= 1'b0;
      sel_q         <= IDX_LAST;
      seg_q         <= 8'hFF;
    end else begin
      pcnt_q <= pcnt_d;
      idx_q  <= idx_d;
      if (wrap) begin
        frame_data_q  <= bus.data_i;
        frame_dp_q    <= bus.dp_i;
        frame_blank_q <= bus.blank_en_i;
      end
      // sel and seg move together, only on tick edges.
      if (tick) begin
        sel_q <= idx_d;
        seg_q <= seg_d;
      end
    end
  end

  assign bus.sel_o = sel_q;
  assign bus.seg_o = seg_q;

endmodule : seg_scan6

// File: tb/tb_seg_scan6.sv
// -----------------------------------------------------------------------------
// tb_seg_scan6
// Directed bench for seg_scan6 with SCAN_CNT=4. Inputs are driven and outputs
// sampled on the falling edge. Frame tasks start on the falling edge just
// before a wrap edge and leave the bench at the same point of the next frame.
// -----------------------------------------------------------------------------
module tb_seg_scan6;

  localparam int unsigned SC = 4;

  logic clk = 1'b0;
  logic rst;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  seg_scan6_if bus ();

  seg_scan6 #(.SCAN_CNT(SC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Hex font constants for bench expectations (active-low, dp off).
  logic [7:0] font [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                            8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  task automatic chk(input string name, input logic [2:0] exp_sel, input logic [7:0] exp_seg);
    vectors++;
    if (bus.sel_o !== exp_sel || bus.seg_o !== exp_seg) begin
      miscompares++;
      $display("FAIL %s: sel/seg = %0d/%02h, required %0d/%02h",
               name, bus.sel_o, bus.seg_o, exp_sel, exp_seg);
    end
  endtask

  // Applies inputs ahead of the wrap edge and checks all six digit slots.
  // exp packs {d5,d4,d3,d2,d1,d0}, 8 bits each.
  task automatic run_frame(input string name, input logic [23:0] d, input logic [5:0] p,
                           input logic b, input logic [47:0] exp);
    bus.data_i = d; bus.dp_i = p; bus.blank_en_i = b;
    for (int k = 0; k < 6; k++) begin
      repeat ((k == 0) ? 1 : SC) @(negedge clk);
      chk($sformatf("%s d%0d", name, k), 3'(k), exp[8*k +: 8]);
    end
    repeat (SC - 1) @(negedge clk);
  endtask

  task automatic test_reset;
    int budget;
    bus.data_i = 24'h0; bus.dp_i = 6'h0; bus.blank_en_i = 1'b0;
    @(negedge clk); rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset hold 0", 3'd5, 8'hFF);
    for (int k = 1; k < SC; k++) begin
      @(negedge clk);
      chk($sformatf("reset hold %0d", k), 3'd5, 8'hFF);
    end
    @(negedge clk);
    chk("reset first digit", 3'd0, 8'hC0);
    // Reset again in the middle of the digit-3 slot.
    budget = 40;
    while (bus.sel_o !== 3'd3 && budget > 0) begin
      @(negedge clk); budget--;
    end
    vectors++;
    if (budget == 0) begin
      miscompares++;
      $display("FAIL reset wait sel3: sel = %0d, required 3 within 40 cycles", bus.sel_o);
    end
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("midscan reset", 3'd5, 8'hFF);
    // Prescaler restarted: still digit 5 / blank for SC-1 more edges.
    for (int k = 1; k < SC; k++) begin
      @(negedge clk);
      chk($sformatf("midscan hold %0d", k), 3'd5, 8'hFF);
    end
  endtask

  task automatic test_full_scan;
    run_frame("scan1", 24'h012345, 6'h00, 1'b0, {8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92});
    run_frame("scan2", 24'h012345, 6'h00, 1'b0, {8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92});
  endtask

  task automatic test_blanking;
    run_frame("blank700", 24'h000700, 6'h00, 1'b1, {8'hFF, 8'hFF, 8'hFF, 8'hF8, 8'hC0, 8'hC0});
    run_frame("blank0",   24'h000000, 6'h00, 1'b1, {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hC0});
    run_frame("noblank0", 24'h000000, 6'h00, 1'b0, {8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0});
  endtask

  task automatic test_dp;
    run_frame("dp", 24'h000003, 6'b000101, 1'b1, {8'hFF, 8'hFF, 8'hFF, 8'h7F, 8'hFF, 8'h30});
  endtask

  task automatic test_tearing;
    bus.data_i = 24'h111111; bus.dp_i = 6'h00; bus.blank_en_i = 1'b0;
    for (int k = 0; k < 6; k++) begin
      repeat ((k == 0) ? 1 : SC) @(negedge clk);
      chk($sformatf("tear d%0d", k), 3'(k), 8'hF9);
      if (k == 2) bus.data_i = 24'h222222;
    end
    repeat (SC - 1) @(negedge clk);
    run_frame("tear next", 24'h222222, 6'h00, 1'b0, {6{8'hA4}});
  endtask

  task automatic test_hex;
    for (int n = 0; n < 16; n++) begin
      logic [7:0] c;
      c = font[n];
      run_frame($sformatf("hex%0h", n), {20'h00000, 4'(n)}, 6'h00, 1'b0,
                {8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, c});
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.data_i = '0; bus.dp_i = '0; bus.blank_en_i = 1'b0;
    test_reset();
    test_full_scan();
    test_blanking();
    test_dp();
    test_tearing();
    test_hex();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_seg_scan6
